// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds default bus widths, the pipeline stage record and the latency cap.
package mem_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int MAX_LATENCY = 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } stage_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU load/store path and the responder.
// master: CPU side (drives req_*, rsp_ready); slave: responder side.
interface data_mem_responder_if
    import mem_pkg::*;
#(
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int ADDR_W = mem_pkg::ADDR_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] rsp_addr;
    logic [3:0]        outstanding;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_addr, outstanding
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_addr, outstanding
    );

endinterface

// File: rtl/mem_word_array.sv
// Single-port word storage, 2^DEPTH_W x DATA_W, no reset.
// Ports: clk_i, we_i, addr_i (word index), wdata_i, rdata_o (word at addr_i).
module mem_word_array #(
    parameter int DATA_W  = 16,
    parameter int DEPTH_W = 10
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [DEPTH_W-1:0] addr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    output logic [DATA_W-1:0]  rdata_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // The caller registers this value at the accepting edge.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency in-order data-memory responder with response backpressure.
// Ports: clk, rst (sync, active-high), bus (slave side of the request/response bus).
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W  = mem_pkg::DATA_W,
    parameter int ADDR_W  = mem_pkg::ADDR_W,
    parameter int DEPTH_W = 10,
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    data_mem_responder_if.slave bus
);

    stage_t             stg_q [LATENCY];
    stage_t             stg_d [LATENCY];
    logic [3:0]         outst_q;
    logic [3:0]         outst_d;
    logic               stall;
    logic               accept;
    logic               rd_acc;
    logic               wr_acc;
    logic               rsp_fire;
    logic [DEPTH_W-1:0] word_idx;
    logic [DATA_W-1:0]  rd_word;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr[0], bus.req_addr[ADDR_W-1:DEPTH_W+1]};

    assign stall    = stg_q[LATENCY-1].valid & ~bus.rsp_ready;
    assign rsp_fire = stg_q[LATENCY-1].valid & bus.rsp_ready;
    // Nothing is accepted in a reset cycle, including writes.
    assign accept   = bus.req_valid & ~stall & ~rst;
    assign wr_acc   = accept & bus.req_wr;
    assign rd_acc   = accept & ~bus.req_wr;
    assign word_idx = bus.req_addr[DEPTH_W:1];

    mem_word_array #(
        .DATA_W  (DATA_W),
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .addr_i  (word_idx),
        .wdata_i (bus.req_wdata),
        .rdata_o (rd_word)
    );

    always_comb begin
        stg_d = stg_q;
        if (!stall) begin
            // Bubbles carry zeros so idle outputs stay clean.
            stg_d[0].valid = rd_acc;
            stg_d[0].addr  = rd_acc ? bus.req_addr : '0;
            stg_d[0].data  = rd_acc ? rd_word : '0;
            for (int i = 1; i < LATENCY; i++) begin
                stg_d[i] = stg_q[i-1];
            end
        end
    end

    always_comb begin
        outst_d = outst_q + {3'b000, rd_acc} - {3'b000, rsp_fire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_q[i] <= '0;
            end
            outst_q <= '0;
        end else begin
            stg_q   <= stg_d;
            outst_q <= outst_d;
        end
    end

    assign bus.req_ready   = ~stall;
    assign bus.rsp_valid   = stg_q[LATENCY-1].valid;
    assign bus.rsp_rdata   = stg_q[LATENCY-1].data;
    assign bus.rsp_addr    = stg_q[LATENCY-1].addr;
    assign bus.outstanding = outst_q;

endmodule
